// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 timing constants, derived line/frame
//               totals, sync window bounds, counter type and the decode
//               record used by the VGA sync generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Default horizontal timing, in pixels
    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;

    // Default vertical timing, in lines
    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;

    // 100 MHz system clock cycles per 25 MHz pixel
    localparam int c_CLK_DIV   = 4;

    // Derived totals and sync windows (inclusive bounds)
    localparam int c_H_TOTAL      = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;   // 800
    localparam int c_V_TOTAL      = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;   // 525
    localparam int c_H_SYNC_START = c_H_VISIBLE + c_H_FRONT;                         // 656
    localparam int c_H_SYNC_END   = c_H_SYNC_START + c_H_SYNC - 1;                   // 751
    localparam int c_V_SYNC_START = c_V_VISIBLE + c_V_FRONT;                         // 490
    localparam int c_V_SYNC_END   = c_V_SYNC_START + c_V_SYNC - 1;                   // 491

    // All position arithmetic is unsigned 10-bit
    localparam int c_CNT_W = 10;
    typedef logic [c_CNT_W-1:0] count_t;

    // One decoded pixel position, registered as a unit so every output
    // field leaves the block on the same edge.
    typedef struct packed {
        logic   hs;
        logic   vs;
        logic   videoOn;
        count_t x;
        count_t y;
    } syncDecode_t;

    // Inclusive range test on counter values
    function automatic logic inRange(input count_t val, input count_t lo, input count_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Index of the last position given the four segment lengths
    function automatic count_t lastIndex(input int vis, input int front, input int sync, input int back);
        return count_t'(vis + front + sync + back - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pix_tick_gen
// Description : Pixel-rate strobe generator. A divider counts 0..CLK_DIV-1
//               and wraps; the strobe is registered so it is high exactly
//               on the cycles where the divider holds CLK_DIV-1.
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-high reset
//               o_pixTick - one-cycle strobe per pixel period
// Revision    : 1.0 - initial release
// ============================================================================
module pix_tick_gen #(
    parameter int CLK_DIV = 4
)(
    input  logic clk,
    input  logic rst,
    output logic o_pixTick
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_divNext;

    always_comb begin
        w_divNext = (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_W'(1);
    end

    // The strobe is computed from the next divider value so that the
    // registered strobe lines up with the registered divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            o_pixTick <= 1'b0;
        end else begin
            r_div     <= w_divNext;
            o_pixTick <= (w_divNext == c_DIV_LAST);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA horizontal/vertical sync generator with colour blanking.
//               Pixel-rate h/v counters are decoded into active-low syncs,
//               visible-area flag and position; every output is registered
//               one Clk_100M after the counter update and mutually aligned.
// Ports       : Clk_100M    - sole clock, rising edge
//               reset       - synchronous active-high reset
//               COLOUR_IN   - 4:4:4 RGB pixel colour from the renderer
//               HS, VS      - active-low horizontal / vertical sync
//               COLOUR_OUT  - blanked colour to the DAC
//               pixel_x/y   - current column / line
//               video_on    - visible-area flag
//               pix_tick    - one-cycle strobe per pixel period
//               frame_start - one-cycle pulse at the first (0,0) output
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK,
    parameter int CLK_DIV   = c_CLK_DIV
)(
    input  logic        Clk_100M,
    input  logic        reset,
    input  logic [11:0] COLOUR_IN,
    output logic        HS,
    output logic        VS,
    output logic [11:0] COLOUR_OUT,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        pix_tick,
    output logic        frame_start
);

    // Timing bounds for this instance, in counter width
    localparam count_t c_H_LAST   = lastIndex(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam count_t c_V_LAST   = lastIndex(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam count_t c_H_VIS    = count_t'(H_VISIBLE);
    localparam count_t c_V_VIS    = count_t'(V_VISIBLE);
    localparam count_t c_HS_START = count_t'(H_VISIBLE + H_FRONT);
    localparam count_t c_HS_END   = count_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam count_t c_VS_START = count_t'(V_VISIBLE + V_FRONT);
    localparam count_t c_VS_END   = count_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        w_pixTick;
    count_t      r_hCount;
    count_t      r_vCount;
    logic        r_frameWrap;
    logic        w_hLast;
    logic        w_vLast;
    syncDecode_t w_dec;

    pix_tick_gen #(
        .CLK_DIV   (CLK_DIV)
    ) u_pixTickGen (
        .clk       (Clk_100M),
        .rst       (reset),
        .o_pixTick (w_pixTick)
    );

    assign pix_tick = w_pixTick;
    assign w_hLast  = (r_hCount == c_H_LAST);
    assign w_vLast  = (r_vCount == c_V_LAST);

    // ------------------------------------------------------------------
    // Position counters. r_frameWrap marks the single cycle in which the
    // counters have just wrapped from the last position back to (0,0);
    // it is never set by reset, so the post-reset frame raises no pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_100M) begin
        if (reset) begin
            r_hCount    <= '0;
            r_vCount    <= '0;
            r_frameWrap <= 1'b0;
        end else begin
            r_frameWrap <= w_pixTick && w_hLast && w_vLast;
            if (w_pixTick) begin
                if (w_hLast) begin
                    r_hCount <= '0;
                    r_vCount <= w_vLast ? '0 : r_vCount + count_t'(1);
                end else begin
                    r_hCount <= r_hCount + count_t'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode of the current counter position
    // ------------------------------------------------------------------
    always_comb begin
        w_dec         = '0;
        w_dec.hs      = ~inRange(r_hCount, c_HS_START, c_HS_END);
        w_dec.vs      = ~inRange(r_vCount, c_VS_START, c_VS_END);
        w_dec.videoOn = (r_hCount < c_H_VIS) && (r_vCount < c_V_VIS);
        w_dec.x       = r_hCount;
        w_dec.y       = r_vCount;
    end

    // ------------------------------------------------------------------
    // Output register: all outputs change on the same edge, so HS and VS
    // cannot glitch when the h and v wraps coincide.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_100M) begin
        if (reset) begin
            HS          <= 1'b1;
            VS          <= 1'b1;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            COLOUR_OUT  <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            HS          <= w_dec.hs;
            VS          <= w_dec.vs;
            video_on    <= w_dec.videoOn;
            pixel_x     <= w_dec.x;
            pixel_y     <= w_dec.y;
            COLOUR_OUT  <= w_dec.videoOn ? COLOUR_IN : 12'h000;
            frame_start <= r_frameWrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen. A reduced-timing
//               instance (32x17 positions, divide-by-4) is checked against
//               a position-from-cycle-count model; a default-timing
//               instance is checked for line timing and colour blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    // Reduced timing for frame-level checks
    localparam int HV = 16, HF = 4, HSY = 6, HB = 6;
    localparam int VV = 10, VF = 2, VSY = 2, VB = 3;
    localparam int TD = 4;
    localparam int HT = HV + HF + HSY + HB;   // 32
    localparam int VT = VV + VF + VSY + VB;   // 17
    localparam int FRAME = HT * VT * TD;      // 2176 cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        defRst = 1'b1;
    logic [11:0] colIn = 12'h000;
    logic [11:0] defColIn = 12'hFFF;

    logic        hs, vs, vo, tk, fs;
    logic [9:0]  px, py;
    logic [11:0] colOut;
    logic        defHs, defVs, defVo, defTk, defFs;
    logic [9:0]  defX, defY;
    logic [11:0] defColOut;
    logic [36:0] dutVec;

    int          nTests = 0;
    int          nFail  = 0;
    int          n      = 0;          // edges since reset released
    logic [11:0] lastCol = 12'h000;   // colour presented at the latest edge

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .CLK_DIV(TD)
    ) dut (
        .Clk_100M(clk), .reset(rst), .COLOUR_IN(colIn),
        .HS(hs), .VS(vs), .COLOUR_OUT(colOut),
        .pixel_x(px), .pixel_y(py), .video_on(vo),
        .pix_tick(tk), .frame_start(fs)
    );

    vga_sync_gen dutDef (
        .Clk_100M(clk), .reset(defRst), .COLOUR_IN(defColIn),
        .HS(defHs), .VS(defVs), .COLOUR_OUT(defColOut),
        .pixel_x(defX), .pixel_y(defY), .video_on(defVo),
        .pix_tick(defTk), .frame_start(defFs)
    );

    assign dutVec = {hs, vs, vo, fs, tk, px, py, colOut};

    // ------------------------------------------------------------------
    // Reference model: after n post-reset edges, (n-1)/TD pixel advances
    // have reached the output stage; position follows by division.
    // ------------------------------------------------------------------
    function automatic logic [36:0] modelVec(input int edges, input logic [11:0] col);
        int q, p, x, y;
        logic mHs, mVs, mVo, mFs, mTk;
        if (edges == 0)
            return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 12'h000};
        q   = (edges - 1) / TD;
        p   = q % (HT * VT);
        x   = p % HT;
        y   = p / HT;
        mVo = (x < HV) && (y < VV);
        mHs = !((x >= HV + HF) && (x < HV + HF + HSY));
        mVs = !((y >= VV + VF) && (y < VV + VF + VSY));
        mTk = ((edges % TD) == TD - 1);
        mFs = (((edges - 1) % TD) == 0) && (p == 0) && (q > 0);
        return {mHs, mVs, mVo, mFs, mTk, 10'(x), 10'(y), mVo ? col : 12'h000};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            if (nFail <= 20)
                $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [11:0] c);
        rst   = r;
        colIn = c;
        @(posedge clk);
        if (r) n = 0;
        else   n = n + 1;
        lastCol = c;
        #1;
    endtask

    // ------------------------------------------------------------------
    // Default-timing instance monitor
    // ------------------------------------------------------------------
    int   defEdges = 0, defCyc = 0, defVoLine0 = 0, defRuleErr = 0, defFsCount = 0;
    logic defPrevHs = 1'b1;
    int   defHsF[$], defHsR[$];

    always @(posedge clk) begin
        if (defRst) defEdges <= 0;
        else        defEdges <= defEdges + 1;
    end

    always @(negedge clk) begin
        if (defEdges >= 1) begin
            defCyc <= defCyc + 1;
            if (defPrevHs && !defHs) defHsF.push_back(defCyc);
            if (!defPrevHs && defHs) defHsR.push_back(defCyc);
            defPrevHs <= defHs;
            if (defVo && (defY == 10'd0)) defVoLine0 <= defVoLine0 + 1;
            if ((defVo !== ((defX < 10'd640) && (defY < 10'd480))) ||
                (defColOut !== (defVo ? 12'hFFF : 12'h000)))
                defRuleErr <= defRuleErr + 1;
            if (defFs) defFsCount <= defFsCount + 1;
        end
    end

    // ------------------------------------------------------------------
    // Table of checkpoints after a clean reset, colour held at 12'hABC
    // ------------------------------------------------------------------
    typedef struct {
        int          edges;
        int          hs, vs, vo, fs, tk, x, y;
        logic [11:0] colOut;
    } vec_t;

    function automatic vec_t mkVec(input int e, input int h, input int v, input int o,
                                   input int f, input int t, input int x, input int y,
                                   input logic [11:0] c);
        vec_t r;
        r.edges = e; r.hs = h; r.vs = v; r.vo = o; r.fs = f; r.tk = t;
        r.x = x; r.y = y; r.colOut = c;
        return r;
    endfunction

    vec_t vecs[$];
    int   cHsF[$], cHsR[$], cVsF[$], cVsR[$], cFs[$], cTick[$];

    initial begin
        logic [36:0] expv;
        logic        prevHs, prevVs, found;
        int          voCount, tickBad, hold;

        //            edges  hs vs vo fs tk   x   y  colour
        vecs.push_back(mkVec(   0, 1, 1, 0, 0, 0,  0,  0, 12'h000));
        vecs.push_back(mkVec(   1, 1, 1, 1, 0, 0,  0,  0, 12'hABC));
        vecs.push_back(mkVec(   3, 1, 1, 1, 0, 1,  0,  0, 12'hABC));
        vecs.push_back(mkVec(   5, 1, 1, 1, 0, 0,  1,  0, 12'hABC));
        vecs.push_back(mkVec(  65, 1, 1, 0, 0, 0, 16,  0, 12'h000));
        vecs.push_back(mkVec(  81, 0, 1, 0, 0, 0, 20,  0, 12'h000));
        vecs.push_back(mkVec( 101, 0, 1, 0, 0, 0, 25,  0, 12'h000));
        vecs.push_back(mkVec( 105, 1, 1, 0, 0, 0, 26,  0, 12'h000));
        vecs.push_back(mkVec( 129, 1, 1, 1, 0, 0,  0,  1, 12'hABC));
        vecs.push_back(mkVec( 159, 1, 1, 1, 0, 1,  7,  1, 12'hABC));
        vecs.push_back(mkVec(1537, 1, 0, 0, 0, 0,  0, 12, 12'h000));
        vecs.push_back(mkVec(1789, 1, 0, 0, 0, 0, 31, 13, 12'h000));
        vecs.push_back(mkVec(1793, 1, 1, 0, 0, 0,  0, 14, 12'h000));
        vecs.push_back(mkVec(2173, 1, 1, 0, 0, 0, 31, 16, 12'h000));
        vecs.push_back(mkVec(2175, 1, 1, 0, 0, 1, 31, 16, 12'h000));
        vecs.push_back(mkVec(2177, 1, 1, 1, 1, 0,  0,  0, 12'hABC));
        vecs.push_back(mkVec(2178, 1, 1, 1, 0, 0,  0,  0, 12'hABC));

        step(1'b1, 12'hABC);
        step(1'b1, 12'hABC);
        step(1'b1, 12'hABC);
        defRst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            while (n < vecs[i].edges) step(1'b0, 12'hABC);
            expv = {1'(vecs[i].hs), 1'(vecs[i].vs), 1'(vecs[i].vo), 1'(vecs[i].fs),
                    1'(vecs[i].tk), 10'(vecs[i].x), 10'(vecs[i].y), vecs[i].colOut};
            check($sformatf("vec%0d_n%0d", i, n), 64'(dutVec), 64'(expv));
        end

        // Reset for one edge on the second VS-low line
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            step(1'b0, 12'($urandom));
            found = (vs == 1'b0) && (py == 10'd13);
        end
        check("reachVsLine", 64'(found), 64'(1));
        step(1'b1, 12'h123);
        check("midVsReset", 64'(dutVec), 64'(modelVec(n, lastCol)));
        check("midVsResetVs", 64'(vs), 64'(1));
        step(1'b0, 12'h456);
        check("postResetOrigin", 64'(dutVec), 64'(modelVec(n, lastCol)));

        // Free-run measurement over two frames
        step(1'b1, 12'h000);
        step(1'b1, 12'h000);
        prevHs = 1'b1; prevVs = 1'b1; voCount = 0; tickBad = 0;
        for (int k = 0; k < 2 * FRAME + 200; k++) begin
            step(1'b0, 12'($urandom));
            if (prevHs && !hs) cHsF.push_back(n);
            if (!prevHs && hs) cHsR.push_back(n);
            if (prevVs && !vs) cVsF.push_back(n);
            if (!prevVs && vs) cVsR.push_back(n);
            if (fs) cFs.push_back(n);
            if (vo && cFs.size() == 1) voCount++;
            if (tk) cTick.push_back(n);
            prevHs = hs;
            prevVs = vs;
        end
        for (int k = 1; k < cTick.size(); k++)
            if (cTick[k] - cTick[k-1] != TD) tickBad++;
        check("hsFallCount", 64'(cHsF.size()), 64'(35));
        check("hsPeriod",  64'(cHsF.size() > 1 ? cHsF[1] - cHsF[0] : -1), 64'(HT * TD));
        check("hsLow",     64'((cHsF.size() > 0 && cHsR.size() > 0) ? cHsR[0] - cHsF[0] : -1), 64'(HSY * TD));
        check("vsFallCount", 64'(cVsF.size()), 64'(2));
        check("vsPeriod",  64'(cVsF.size() > 1 ? cVsF[1] - cVsF[0] : -1), 64'(FRAME));
        check("vsLow",     64'((cVsF.size() > 0 && cVsR.size() > 0) ? cVsR[0] - cVsF[0] : -1), 64'(VSY * HT * TD));
        check("frameStartCount", 64'(cFs.size()), 64'(2));
        check("frameStartFirst", 64'(cFs.size() > 0 ? cFs[0] : -1), 64'(FRAME + 1));
        check("frameStartPeriod", 64'(cFs.size() > 1 ? cFs[1] - cFs[0] : -1), 64'(FRAME));
        check("videoOnPerFrame", 64'(voCount), 64'(HV * VV * TD));
        check("tickFirst", 64'(cTick.size() > 0 ? cTick[0] : -1), 64'(TD - 1));
        check("tickSpacing", 64'(tickBad), 64'(0));

        // Random colour with occasional resets once a wrap has been seen
        step(1'b1, 12'h000);
        step(1'b1, 12'h000);
        check("randResetState", 64'(dutVec), 64'(modelVec(n, lastCol)));
        hold = 0;
        for (int i = 0; i < 7000; i++) begin
            logic r;
            r = 1'b0;
            if (hold > 0) begin
                r = 1'b1;
                hold--;
            end else if (n > FRAME + 120 && $urandom_range(0, 999) == 0) begin
                r = 1'b1;
                hold = int'($urandom_range(0, 2));
            end
            step(r, 12'($urandom));
            check($sformatf("rand%0d_n%0d", i, n), 64'(dutVec), 64'(modelVec(n, lastCol)));
        end

        // Default-timing instance: line timing and blanking
        check("defHsFallsSeen", 64'(defHsF.size() >= 2), 64'(1));
        check("defHsPeriod", 64'(defHsF.size() > 1 ? defHsF[1] - defHsF[0] : -1), 64'(3200));
        check("defHsLow", 64'((defHsF.size() > 0 && defHsR.size() > 0) ? defHsR[0] - defHsF[0] : -1), 64'(384));
        check("defVideoLine0", 64'(defVoLine0), 64'(640 * 4));
        check("defBlankRule", 64'(defRuleErr), 64'(0));
        check("defNoPostResetFrameStart", 64'(defFsCount), 64'(0));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, HS pulse width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels; line total = 800.
REQ-005 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, VS pulse width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines; frame total = 525.
REQ-009 Parameter CLK_DIV, default 4, Clk_100M cycles per pixel (25 MHz pixel rate).
REQ-010 Clk_100M  input  1  sole clock; the block has one clock, and all logic is rising-edge.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 COLOUR_IN  input  12  pixel colour from the renderer, 4:4:4 RGB.
REQ-013 HS  output  1  horizontal sync, active-low.
REQ-014 VS  output  1  vertical sync, active-low.
REQ-015 COLOUR_OUT  output  12  blanked colour to the DAC.
REQ-016 pixel_x  output  10  current column, 0..799.
REQ-017 pixel_y  output  10  current line, 0..524.
REQ-018 video_on  output  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
REQ-019 pix_tick  output  1  one-Clk_100M-cycle strobe per pixel period.
REQ-020 frame_start  output  1  one-cycle pulse when the counters return to (0,0).

Function
REQ-021 Divider counter counts 0..CLK_DIV-1 and wraps; pix_tick SHALL be high on exactly the cycles where divider = CLK_DIV-1.
REQ-022 h_count SHALL advance only on pix_tick and wrap from 799 to 0.
REQ-023 v_count SHALL advance only on pix_tick with h_count = 799, and wrap from 524 to 0.
REQ-024 HS SHALL be low iff the h decode is in [656,751], i.e. H_VISIBLE+H_FRONT to H_VISIBLE+H_FRONT+H_SYNC-1.
REQ-025 VS SHALL be low iff the v decode is in [490,491].
REQ-026 HS, VS, video_on, pixel_x, pixel_y and COLOUR_OUT SHALL be registered and mutually aligned, with one Clk_100M of latency after the counter update.
REQ-027 COLOUR_OUT SHALL equal COLOUR_IN registered when the aligned video_on is 1, and 12'h000 otherwise.
REQ-028 frame_start SHALL pulse for exactly one Clk_100M cycle, aligned with the first output cycle where pixel_x = 0 and pixel_y = 0.
REQ-029 HS and VS SHALL be mutually independent; coincidence of the h wrap and the v wrap SHALL produce no glitch.
REQ-030 All arithmetic SHALL be unsigned 10-bit; counters SHALL never exceed their total minus 1.

Reset
REQ-031 While reset is high: divider, h_count and v_count = 0; HS = 1; VS = 1; video_on = 0; COLOUR_OUT = 0; pixel_x = 0; pixel_y = 0; pix_tick = 0; frame_start = 0.
REQ-032 Reset asserted mid-frame SHALL return all state to REQ-031 values on the next edge, with no partial sync pulse extended.
REQ-033 On the first cycle after reset deasserts, the outputs SHALL decode (0,0): video_on = 1, and frame_start SHALL NOT pulse for the post-reset frame.

Structure
REQ-034 Timing constants and the derived totals (H_TOTAL = 800, V_TOTAL = 525, sync start/end) SHALL live in the shared package vga_timing_pkg.
REQ-035 One sub-module, pix_tick_gen (the CLK_DIV divider), is natural; the h/v counters and decode stay in vga_sync_gen.
REQ-036 Target size is 120-250 lines of RTL, with no latches and no combinational outputs.

Verification
REQ-037 Free-run after reset -> HS period 3200 Clk_100M cycles with low time 384 cycles; VS period 1,680,000 cycles with low time 6400 cycles.
REQ-038 Count video_on cycles over one frame -> 640*480*4 = 1,228,800 cycles high.
REQ-039 Drive COLOUR_IN = 12'hFFF constantly -> COLOUR_OUT = 12'h000 whenever pixel_x >= 640 or pixel_y >= 480, and 12'hFFF otherwise.
REQ-040 Observe the wrap at pixel_x = 799, pixel_y = 524 -> next pixel is (0,0), frame_start pulses exactly once per 1,680,000 cycles, and VS shows no glitch.
REQ-041 Assert reset for 1 cycle at pixel_y = 491, during VS low -> VS = 1 on the next edge, and counters restart from (0,0).
REQ-042 Check pix_tick spacing -> exactly 4 cycles apart, and no tick while reset is high.
